// File: rtl/timer_pkg.sv
// Shared constants for the interval timer: state encoding, mode values, default widths.
package timer_pkg;

    localparam int unsigned WIDTH_DEF      = 8;
    localparam int unsigned PRESCALE_W_DEF = 4;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_PAUSE_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_PAUSE = ST_PAUSE_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Config handshake, run controls and status of the interval timer.
interface interval_timer_ctrl_if import timer_pkg::*; #(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [WIDTH-1:0]      cfg_period;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic                  cfg_mode;
    logic                  start;
    logic                  stop;
    logic [WIDTH-1:0]      cnt_o;
    logic                  tick;
    logic                  done;
    logic                  busy;

    modport master (
        output cfg_valid, cfg_period, cfg_prescale, cfg_mode, start, stop,
        input  cfg_ready, cnt_o, tick, done, busy
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_prescale, cfg_mode, start, stop,
        output cfg_ready, cnt_o, tick, done, busy
    );
endinterface

// File: rtl/prescaled_counter.sv
// Prescaler plus WIDTH-bit counter running 0..period-1; flags the terminal count.
module prescaled_counter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      period,
    output logic [WIDTH-1:0]      count,
    output logic                  at_term_c
);
    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0]      last_cnt_c;
    logic                  last_step_c;

    assign last_cnt_c  = period - CNT_ONE;
    assign last_step_c = (pre_q == prescale);
    // Terminal event is reported unqualified; the controller decides whether it is taken.
    assign at_term_c   = last_step_c && (cnt_q == last_cnt_c);
    assign count       = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        pre_d = pre_q;
        if (clear) begin
            cnt_d = '0;
            pre_d = '0;
        end else if (enable) begin
            if (last_step_c) begin
                pre_d = '0;
                cnt_d = (cnt_q == last_cnt_c) ? '0 : cnt_q + CNT_ONE;
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            pre_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: config shadows, run/pause/abort FSM, tick and done generation.
module interval_timer_ctrl import timer_pkg::*; #(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    interval_timer_ctrl_if.slave   bus
);
    state_e                state_q, state_d;
    logic [WIDTH-1:0]      period_q, period_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  mode_q, mode_d;
    logic                  tick_q, tick_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;

    logic                  cnt_clear_c, cnt_en_c, at_term_c;
    logic [WIDTH-1:0]      cnt_c;
    logic                  cfg_hs_c, go_c;

    assign cfg_hs_c = bus.cfg_valid && ready_q;
    // stop beats start; a zero period never launches a run
    assign go_c     = bus.start && !bus.stop && (period_q != '0);

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        prescale_d  = prescale_q;
        mode_d      = mode_q;
        tick_d      = 1'b0;
        done_d      = done_q;
        cnt_clear_c = 1'b0;
        cnt_en_c    = 1'b0;

        if (cfg_hs_c) begin
            period_d   = bus.cfg_period;
            prescale_d = bus.cfg_prescale;
            mode_d     = bus.cfg_mode;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go_c) begin
                    state_d     = ST_RUN;
                    cnt_clear_c = 1'b1;
                    done_d      = 1'b0;
                end else if (cfg_hs_c) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (at_term_c) begin
                    tick_d = 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        cnt_en_c = 1'b1;
                        if (bus.stop) state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else if (bus.stop) begin
                    state_d = ST_PAUSE;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    state_d     = ST_IDLE;
                    cnt_clear_c = 1'b1;
                end else if (bus.start) begin
                    // the resume edge itself counts, so it may land on the terminal event
                    if (at_term_c && (mode_q == MODE_ONESHOT)) begin
                        tick_d  = 1'b1;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        tick_d   = at_term_c;
                        cnt_en_c = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            period_q   <= '0;
            prescale_q <= '0;
            mode_q     <= MODE_ONESHOT;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            mode_q     <= mode_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    prescaled_counter #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear_c),
        .enable    (cnt_en_c),
        .prescale  (prescale_q),
        .period    (period_q),
        .count     (cnt_c),
        .at_term_c (at_term_c)
    );

    assign bus.cnt_o     = cnt_c;
    assign bus.tick      = tick_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.cfg_ready = ready_q;
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl with an elapsed-time reference model.
module tb_interval_timer_ctrl;
    localparam int unsigned W  = 8;
    localparam int unsigned PW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    interval_timer_ctrl_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

    interval_timer_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_e;
    typedef struct {
        mst_e st;
        int   P;
        int   p;
        bit   periodic;
        int   elapsed;   // counting cycles since the current period began
        int   cnt;
        bit   tick;
        bit   done;
    } model_t;

    model_t m;
    int n_chk  = 0;
    int n_pass = 0;

    function automatic model_t m_reset();
        model_t r;
        r.st = M_IDLE; r.P = 0; r.p = 0; r.periodic = 1'b0;
        r.elapsed = 0; r.cnt = 0; r.tick = 1'b0; r.done = 1'b0;
        return r;
    endfunction

    function automatic model_t m_step(model_t c, bit v, int cp, int cpre, bit cmode, bit s, bit t);
        model_t n = c;
        int per = c.P * (c.p + 1);
        bit adv = 1'b0;
        bit hs  = v && (c.st == M_IDLE || c.st == M_DONE);
        n.tick = 1'b0;
        case (c.st)
            M_IDLE, M_DONE: begin
                if (s && !t && c.P != 0) begin
                    n.st = M_RUN; n.elapsed = 0; n.cnt = 0; n.done = 1'b0;
                end else if (hs) begin
                    n.st = M_IDLE; n.done = 1'b0;
                end
            end
            M_RUN: begin
                if (t) n.st = M_PAUSE;
                if (!t || (c.elapsed + 1 == per)) adv = 1'b1;
            end
            M_PAUSE: begin
                if (t) begin
                    n.st = M_IDLE; n.elapsed = 0; n.cnt = 0;
                end else if (s) begin
                    n.st = M_RUN; adv = 1'b1;
                end
            end
            default: ;
        endcase
        if (adv) begin
            n.elapsed = c.elapsed + 1;
            if (n.elapsed == per) begin
                n.tick = 1'b1;
                if (c.periodic) begin
                    n.elapsed = 0; n.cnt = 0;
                end else begin
                    n.st = M_DONE; n.done = 1'b1; n.cnt = c.P - 1;
                end
            end else begin
                n.cnt = n.elapsed / (c.p + 1);
            end
        end
        if (hs) begin
            n.P = cp; n.p = cpre; n.periodic = cmode;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= m_reset();
        else m <= m_step(m, bus.cfg_valid, int'(bus.cfg_period), int'(bus.cfg_prescale),
                         bus.cfg_mode, bus.start, bus.stop);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic compare_model();
        bit busy_exp;
        busy_exp = (m.st == M_RUN) || (m.st == M_PAUSE);
        chk("model cnt_o",     32'(bus.cnt_o),     32'(m.cnt));
        chk("model tick",      32'(bus.tick),      32'(m.tick));
        chk("model done",      32'(bus.done),      32'(m.done));
        chk("model busy",      32'(bus.busy),      32'(busy_exp));
        chk("model cfg_ready", 32'(bus.cfg_ready), 32'(!busy_exp));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
            compare_model();
        end
    endtask

    task automatic configure(input int P, input int p, input bit mode);
        bus.cfg_valid    = 1'b1;
        bus.cfg_period   = W'(P);
        bus.cfg_prescale = PW'(p);
        bus.cfg_mode     = mode;
        cyc(1);
        bus.cfg_valid    = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_prescale = '0;
        bus.cfg_mode = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("reset cnt_o", 32'(bus.cnt_o), 0);
        chk("reset tick", 32'(bus.tick), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset cfg_ready", 32'(bus.cfg_ready), 1);
        #20 reset = 1'b1;
        cyc(2);

        // periodic P=4 p=0
        configure(4, 0, 1'b1);
        pulse_start();
        chk("p4 entry cnt", 32'(bus.cnt_o), 0);
        chk("p4 entry busy", 32'(bus.busy), 1);
        cyc(3);
        chk("p4 cnt3", 32'(bus.cnt_o), 3);
        cyc(1);
        chk("p4 tick1", 32'(bus.tick), 1);
        chk("p4 wrap cnt", 32'(bus.cnt_o), 0);
        cyc(4);
        chk("p4 tick2", 32'(bus.tick), 1);
        cyc(4);
        chk("p4 tick3", 32'(bus.tick), 1);
        cyc(1);
        pulse_stop();
        pulse_stop();
        chk("p4 abort busy", 32'(bus.busy), 0);
        chk("p4 abort cnt", 32'(bus.cnt_o), 0);

        // one-shot P=3 p=1
        configure(3, 1, 1'b0);
        pulse_start();
        cyc(5);
        chk("os cnt before end", 32'(bus.cnt_o), 2);
        chk("os done before end", 32'(bus.done), 0);
        cyc(1);
        chk("os tick", 32'(bus.tick), 1);
        chk("os done", 32'(bus.done), 1);
        chk("os hold cnt", 32'(bus.cnt_o), 2);
        chk("os busy", 32'(bus.busy), 0);
        chk("os cfg_ready", 32'(bus.cfg_ready), 1);
        cyc(1);
        chk("os tick drops", 32'(bus.tick), 0);
        chk("os done level", 32'(bus.done), 1);

        // one-shot: stop on the terminal cycle is dropped
        configure(2, 0, 1'b0);
        chk("cfg clears done", 32'(bus.done), 0);
        pulse_start();
        cyc(1);
        pulse_stop();
        chk("os stop-term done", 32'(bus.done), 1);
        chk("os stop-term busy", 32'(bus.busy), 0);

        // periodic P=8: pause, resume, abort
        configure(8, 0, 1'b1);
        pulse_start();
        cyc(2);
        pulse_stop();
        chk("pause freeze cnt", 32'(bus.cnt_o), 2);
        chk("pause busy", 32'(bus.busy), 1);
        cyc(5);
        chk("pause hold cnt", 32'(bus.cnt_o), 2);
        pulse_start();
        chk("resume cnt", 32'(bus.cnt_o), 3);
        pulse_stop();
        pulse_stop();
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort cnt", 32'(bus.cnt_o), 0);

        // config offered during RUN is held off
        pulse_start();
        bus.cfg_valid = 1'b1; bus.cfg_period = W'(3); bus.cfg_mode = 1'b0;
        cyc(1);
        chk("run cfg_ready", 32'(bus.cfg_ready), 0);
        cyc(2);
        bus.cfg_valid = 1'b0;
        cyc(5);
        chk("period kept tick", 32'(bus.tick), 1);
        pulse_stop();
        pulse_stop();
        configure(0, 0, 1'b1);
        pulse_start();
        chk("P0 start busy", 32'(bus.busy), 0);

        // simultaneous start/stop in IDLE, stop on periodic terminal
        configure(4, 0, 1'b1);
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("start+stop idle busy", 32'(bus.busy), 0);
        pulse_start();
        cyc(3);
        pulse_stop();
        chk("stop-term tick", 32'(bus.tick), 1);
        chk("stop-term cnt", 32'(bus.cnt_o), 0);
        chk("stop-term busy", 32'(bus.busy), 1);
        cyc(1);
        chk("stop-term paused cnt", 32'(bus.cnt_o), 0);
        pulse_stop();

        // prescaled pause/resume
        configure(3, 2, 1'b1);
        pulse_start();
        cyc(4);
        pulse_stop();
        cyc(3);
        pulse_start();
        cyc(12);
        pulse_stop();
        pulse_stop();

        // P=1: every counting cycle is terminal, including the resume edge
        configure(1, 0, 1'b1);
        pulse_start();
        cyc(3);
        pulse_stop();
        pulse_start();
        cyc(2);
        pulse_stop();
        pulse_stop();

        // maximum period one-shot
        configure(255, 0, 1'b0);
        pulse_start();
        cyc(255);
        chk("max done", 32'(bus.done), 1);
        chk("max cnt", 32'(bus.cnt_o), 254);

        // asynchronous reset mid-run
        configure(8, 0, 1'b1);
        pulse_start();
        cyc(5);
        chk("pre-reset cnt", 32'(bus.cnt_o), 5);
        #1 reset = 1'b0;
        #1;
        chk("async cnt_o", 32'(bus.cnt_o), 0);
        chk("async tick", 32'(bus.tick), 0);
        chk("async done", 32'(bus.done), 0);
        chk("async busy", 32'(bus.busy), 0);
        chk("async cfg_ready", 32'(bus.cfg_ready), 1);
        #13 reset = 1'b1;
        cyc(10);
        chk("post-reset tick", 32'(bus.tick), 0);
        chk("post-reset busy", 32'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
